// File: rtl/debounce_passo.sv
// debounce_passo: two-button debouncer that turns accepted presses into single-cycle step pulses.
// Define DEBOUNCE_PASSO_AUTO_REPEAT_EN to compile in auto-repeat while a button is held.
module debounce_passo #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk_2,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic step,
  output logic step_down,
  output logic up_level,
  output logic down_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("debounce_passo: parameter out of range");
  end

`ifdef DEBOUNCE_PASSO_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BLOCK} state_t;

  localparam int TLIM = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = (TLIM > 2) ? $clog2(TLIM) : 1;
  localparam logic [TW-1:0] TIMER_MAX   = TW'(TLIM - 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic [TW-1:0] timer_reg;
  logic [TW-1:0] timer_next;
`else
  typedef enum logic [1:0] {IDLE, HOLD, BLOCK} state_t;
`endif

  state_t     state_reg;
  state_t     state_next;
  logic       step_reg;
  logic       step_next;
  logic       dir_reg;
  logic       dir_next;
  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] level_prev_reg;
  logic [1:0] rise;
  logic       held;
  logic       other;

  // bit 0 = up button, bit 1 = down button throughout
  assign raw = {btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          meta_reg;
      logic          sync_reg;
      logic          level_reg;
      logic [CW-1:0] count_reg;

      // Level flips only after DEBOUNCE_CYCLES+1 consecutive disagreeing samples.
      always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
          meta_reg  <= 1'b0;
          sync_reg  <= 1'b0;
          level_reg <= 1'b0;
          count_reg <= '0;
        end else begin
          meta_reg <= raw[gi];
          sync_reg <= meta_reg;
          if (sync_reg == level_reg) begin
            count_reg <= '0;
          end else if (count_reg == CW'(DEBOUNCE_CYCLES)) begin
            level_reg <= ~level_reg;
            count_reg <= '0;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
      end

      assign level[gi] = level_reg;
    end
  endgenerate

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      step_reg       <= 1'b0;
      dir_reg        <= 1'b0;
      level_prev_reg <= 2'b00;
`ifdef DEBOUNCE_PASSO_AUTO_REPEAT_EN
      timer_reg      <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      step_reg       <= step_next;
      dir_reg        <= dir_next;
      level_prev_reg <= level;
`ifdef DEBOUNCE_PASSO_AUTO_REPEAT_EN
      timer_reg      <= timer_next;
`endif
    end
  end

  // dir_reg doubles as "which button owns HOLD/REPEAT"; release beats other-press beats timer.
  always_comb begin
    state_next = state_reg;
    step_next  = 1'b0;
    dir_next   = dir_reg;
    rise       = level & ~level_prev_reg;
    held       = dir_reg ? level[1] : level[0];
    other      = dir_reg ? level[0] : level[1];
`ifdef DEBOUNCE_PASSO_AUTO_REPEAT_EN
    timer_next = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + TW'(1);
`endif
    case (state_reg)
      IDLE: begin
        if (rise == 2'b11) begin
          state_next = BLOCK;
        end else if (rise != 2'b00) begin
          step_next  = 1'b1;
          dir_next   = rise[1];
          state_next = HOLD;
`ifdef DEBOUNCE_PASSO_AUTO_REPEAT_EN
          timer_next = '0;
`endif
        end
      end
      HOLD: begin
        if (!held) begin
          state_next = IDLE;
        end else if (other) begin
          state_next = BLOCK;
        end
`ifdef DEBOUNCE_PASSO_AUTO_REPEAT_EN
        else if (timer_reg >= DELAY_LAST && !step_reg) begin
          step_next  = 1'b1;
          state_next = REPEAT;
          timer_next = '0;
        end
`endif
      end
`ifdef DEBOUNCE_PASSO_AUTO_REPEAT_EN
      REPEAT: begin
        if (!held) begin
          state_next = IDLE;
        end else if (other) begin
          state_next = BLOCK;
        end else if (timer_reg >= PERIOD_LAST && !step_reg) begin
          step_next  = 1'b1;
          timer_next = '0;
        end
      end
`endif
      BLOCK: begin
        if (level == 2'b00) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign step       = step_reg;
  assign step_down  = dir_reg;
  assign up_level   = level[0];
  assign down_level = level[1];

endmodule
